// File: rtl/rf16_32bits_if.sv
// Request/response bundle for the 16x32 register bank: write port, bulk clear and registered read port.
interface rf16_32bits_if #(
  parameter int DATA_W = 32
);
  logic              we;
  logic [3:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clr;
  logic              re;
  logic [3:0]        rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_err;

  modport master (
    output we, wr_addr, wr_data, clr, re, rd_addr,
    input  rd_data, rd_valid, rd_err
  );

  modport slave (
    input  we, wr_addr, wr_data, clr, re, rd_addr,
    output rd_data, rd_valid, rd_err
  );
endinterface

// File: rtl/rf16_32bits.sv
// 16-entry x 32-bit register bank feeding the 16:1 wide read mux, with its own
// registered read port (write-first bypass), per-entry valid bits and bulk clear.
module rf16_32bits #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  rf16_32bits_if.slave      bus,
  output logic [DEPTH-1:0]  valid,
  output logic [DATA_W-1:0] q0,
  output logic [DATA_W-1:0] q1,
  output logic [DATA_W-1:0] q2,
  output logic [DATA_W-1:0] q3,
  output logic [DATA_W-1:0] q4,
  output logic [DATA_W-1:0] q5,
  output logic [DATA_W-1:0] q6,
  output logic [DATA_W-1:0] q7,
  output logic [DATA_W-1:0] q8,
  output logic [DATA_W-1:0] q9,
  output logic [DATA_W-1:0] q10,
  output logic [DATA_W-1:0] q11,
  output logic [DATA_W-1:0] q12,
  output logic [DATA_W-1:0] q13,
  output logic [DATA_W-1:0] q14,
  output logic [DATA_W-1:0] q15
);

  logic [DATA_W-1:0] entry_q [DEPTH];
  logic [DATA_W-1:0] entry_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  wr_sel;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_err_q, rd_err_d;

  // One-hot write enable decoded from the write address.
  always_comb begin
    wr_sel = '0;
    if (bus.we) begin
      wr_sel[bus.wr_addr] = 1'b1;
    end
  end

  // Next bank state: a clear wipes everything first, then the write lands on top.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = bus.clr ? '0 : entry_q[i];
      if (wr_sel[i]) begin
        entry_d[i] = bus.wr_data;
      end
    end
    valid_d = (bus.clr ? '0 : valid_q) | wr_sel;
  end

  // Read port next state: write-first bypass, then clear, then the stored entry.
  always_comb begin
    rd_valid_d = bus.re;
    rd_err_d   = 1'b0;
    rd_data_d  = rd_data_q;
    if (bus.re) begin
      if (bus.we && (bus.wr_addr == bus.rd_addr)) begin
        rd_data_d = bus.wr_data;
        rd_err_d  = 1'b0;
      end else if (bus.clr) begin
        rd_data_d = '0;
        rd_err_d  = 1'b1;
      end else begin
        rd_data_d = entry_q[bus.rd_addr];
        rd_err_d  = ~valid_q[bus.rd_addr];
      end
    end
  end

  // State registers; reset wins over write, clear and read in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      valid_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
      valid_q    <= valid_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_err   = rd_err_q;
  assign valid        = valid_q;

  assign q0  = entry_q[0];
  assign q1  = entry_q[1];
  assign q2  = entry_q[2];
  assign q3  = entry_q[3];
  assign q4  = entry_q[4];
  assign q5  = entry_q[5];
  assign q6  = entry_q[6];
  assign q7  = entry_q[7];
  assign q8  = entry_q[8];
  assign q9  = entry_q[9];
  assign q10 = entry_q[10];
  assign q11 = entry_q[11];
  assign q12 = entry_q[12];
  assign q13 = entry_q[13];
  assign q14 = entry_q[14];
  assign q15 = entry_q[15];

endmodule

// File: tb/tb_rf16_32bits.sv
// Directed, table-driven bench for the rf16_32bits register bank.
module tb_rf16_32bits;

  logic        clk;
  logic        reset;
  logic [15:0] valid;
  logic [31:0] q_arr [16];

  int checks_made;
  int fails_seen;

  rf16_32bits_if #(.DATA_W(32)) bus_if ();

  rf16_32bits dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave),
    .valid (valid),
    .q0    (q_arr[0]),
    .q1    (q_arr[1]),
    .q2    (q_arr[2]),
    .q3    (q_arr[3]),
    .q4    (q_arr[4]),
    .q5    (q_arr[5]),
    .q6    (q_arr[6]),
    .q7    (q_arr[7]),
    .q8    (q_arr[8]),
    .q9    (q_arr[9]),
    .q10   (q_arr[10]),
    .q11   (q_arr[11]),
    .q12   (q_arr[12]),
    .q13   (q_arr[13]),
    .q14   (q_arr[14]),
    .q15   (q_arr[15])
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        clr;
    logic        re;
    logic [3:0]  ra;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_err;
    logic [15:0] e_mask;
    int          q_idx;
    logic [31:0] e_q;
    string       name;
  } vec_t;

  vec_t vecs [$];

  task automatic applyStimulus(input logic rst, input logic we, input logic [3:0] wa,
                               input logic [31:0] wd, input logic clr, input logic re,
                               input logic [3:0] ra);
    reset          = rst;
    bus_if.we      = we;
    bus_if.wr_addr = wa;
    bus_if.wr_data = wd;
    bus_if.clr     = clr;
    bus_if.re      = re;
    bus_if.rd_addr = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks_made++;
    if (got !== exp) begin
      fails_seen++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic e_valid, input logic [31:0] e_data,
                             input logic e_err, input logic [15:0] e_mask);
    checkValue({name, " rd_valid"}, {31'b0, bus_if.rd_valid}, {31'b0, e_valid});
    checkValue({name, " rd_data"}, bus_if.rd_data, e_data);
    checkValue({name, " rd_err"}, {31'b0, bus_if.rd_err}, {31'b0, e_err});
    checkValue({name, " valid"}, {16'b0, valid}, {16'b0, e_mask});
  endtask

  task automatic checkQ(input string name, input int idx, input logic [31:0] exp);
    checkValue($sformatf("%s q%0d", name, idx), q_arr[idx], exp);
  endtask

  initial begin
    checks_made = 0;
    fails_seen  = 0;
    reset          = 1'b1;
    bus_if.we      = 1'b0;
    bus_if.wr_addr = 4'd0;
    bus_if.wr_data = 32'h0;
    bus_if.clr     = 1'b0;
    bus_if.re      = 1'b0;
    bus_if.rd_addr = 4'd0;

    vecs.push_back('{1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0,
                     1'b0, 32'h0, 1'b0, 16'h0000, 0, 32'h0, "reset0"});
    vecs.push_back('{1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0,
                     1'b0, 32'h0, 1'b0, 16'h0000, 15, 32'h0, "reset1"});
    for (int n = 0; n < 16; n++) begin
      vecs.push_back('{1'b0, 1'b1, 4'(n), 32'hA5A5_0000 + 32'(n), 1'b0, 1'b0, 4'd0,
                       1'b0, 32'h0, 1'b0, 16'((32'h1 << (n + 1)) - 1), n,
                       32'hA5A5_0000 + 32'(n), $sformatf("write%0d", n)});
    end
    for (int n = 0; n < 16; n++) begin
      vecs.push_back('{1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 4'(n),
                       1'b1, 32'hA5A5_0000 + 32'(n), 1'b0, 16'hFFFF, n,
                       32'hA5A5_0000 + 32'(n), $sformatf("read%0d", n)});
    end
    vecs.push_back('{1'b0, 1'b1, 4'd7, 32'hDEAD_BEEF, 1'b0, 1'b1, 4'd7,
                     1'b1, 32'hDEAD_BEEF, 1'b0, 16'hFFFF, 7, 32'hDEAD_BEEF, "bypass7"});
    vecs.push_back('{1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd7,
                     1'b0, 32'hDEAD_BEEF, 1'b0, 16'hFFFF, 7, 32'hDEAD_BEEF, "idle_hold"});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd,
                    vecs[i].clr, vecs[i].re, vecs[i].ra);
      checkOutput(vecs[i].name, vecs[i].e_valid, vecs[i].e_data, vecs[i].e_err, vecs[i].e_mask);
      checkQ(vecs[i].name, vecs[i].q_idx, vecs[i].e_q);
    end

    applyStimulus(1'b0, 1'b1, 4'd3, 32'h1234_5678, 1'b1, 1'b1, 4'd5);
    checkOutput("clr_we3", 1'b1, 32'h0, 1'b1, 16'h0008);
    for (int i = 0; i < 16; i++) begin
      checkQ("clr_we3", i, (i == 3) ? 32'h1234_5678 : 32'h0);
    end

    applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 4'd5);
    checkOutput("read5_after_clr", 1'b1, 32'h0, 1'b1, 16'h0008);

    applyStimulus(1'b0, 1'b1, 4'd9, 32'hCAFE_0009, 1'b1, 1'b1, 4'd9);
    checkOutput("clr_bypass9", 1'b1, 32'hCAFE_0009, 1'b0, 16'h0200);
    checkQ("clr_bypass9", 9, 32'hCAFE_0009);

    applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0);
    checkOutput("idle_after_clr", 1'b0, 32'hCAFE_0009, 1'b0, 16'h0200);
    checkQ("idle_after_clr", 3, 32'h0);

    applyStimulus(1'b0, 1'b1, 4'd0, 32'h1111_1111, 1'b0, 1'b0, 4'd0);
    checkQ("write0_first", 0, 32'h1111_1111);
    applyStimulus(1'b0, 1'b1, 4'd0, 32'h2222_2222, 1'b0, 1'b0, 4'd0);
    checkQ("write0_second", 0, 32'h2222_2222);
    applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 4'd0);
    checkOutput("read0_last_wins", 1'b1, 32'h2222_2222, 1'b0, 16'h0201);

    applyStimulus(1'b0, 1'b1, 4'd2, 32'h0000_BEE2, 1'b0, 1'b0, 4'd0);
    checkOutput("write2", 1'b0, 32'h2222_2222, 1'b0, 16'h0205);
    checkQ("write2", 2, 32'h0000_BEE2);

    applyStimulus(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 4'd2);
    checkOutput("reset_midstream", 1'b0, 32'h0, 1'b0, 16'h0000);
    checkQ("reset_midstream", 2, 32'h0);

    applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 4'd15);
    checkOutput("read15_unwritten", 1'b1, 32'h0, 1'b1, 16'h0000);

    applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 4'd2);
    checkOutput("read2_after_reset", 1'b1, 32'h0, 1'b1, 16'h0000);

    applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0);
    checkOutput("final_idle", 1'b0, 32'h0, 1'b0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks_made, fails_seen);
    $finish;
  end

endmodule
